// File: rtl/led_blinker_multi.sv
// Multi-channel LED driver: shared prescaler timebase and PWM counter, with
// per-channel off / on / blink / PWM modes and a global phase-realign strobe.
module led_blinker_multi #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned DIV_W    = 8,
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [DIV_W-1:0]    cfg_val,
  input  logic                sync_i,
  output logic                tick_o,
  output logic [CHANNELS-1:0] led_o
);

  localparam int unsigned PRE_W = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_PWM   = 2'b11;

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [DIV_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             tick_q, tick_now;

  logic [CHANNELS-1:0][1:0]       mode_q, mode_d;
  logic [CHANNELS-1:0][DIV_W-1:0] val_q, val_d;
  logic [CHANNELS-1:0][DIV_W-1:0] phase_q, phase_d;
  logic [CHANNELS-1:0]            blink_q, blink_d;
  logic [CHANNELS-1:0]            led_q, led_d;

  // Next-state for the shared timebase, channel state and LED drive.
  always_comb begin
    // Internal tick: the prescaler wrap cycle, suppressed when sync realigns it.
    tick_now  = (pre_cnt_q == PRE_MAX) && !sync_i;
    pre_cnt_d = (sync_i || (pre_cnt_q == PRE_MAX)) ? '0 : pre_cnt_q + PRE_W'(1);
    pwm_cnt_d = sync_i ? '0 : pwm_cnt_q + DIV_W'(1);

    mode_d  = mode_q;
    val_d   = val_q;
    phase_d = phase_q;
    blink_d = blink_q;
    led_d   = '0;

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      unique case (mode_q[i])
        MODE_OFF:   led_d[i] = 1'b0;
        MODE_ON:    led_d[i] = 1'b1;
        MODE_BLINK: led_d[i] = blink_q[i];
        MODE_PWM:   led_d[i] = (pwm_cnt_q < val_q[i]);
        default:    led_d[i] = 1'b0;
      endcase

      if ((mode_q[i] == MODE_BLINK) && tick_now) begin
        if (phase_q[i] == val_q[i]) begin
          phase_d[i] = '0;
          blink_d[i] = ~blink_q[i];
        end else begin
          phase_d[i] = phase_q[i] + DIV_W'(1);
        end
      end

      if (sync_i) begin
        phase_d[i] = '0;
        blink_d[i] = 1'b1;
      end

      // A write overrides any toggle landing on the same edge; out-of-range
      // indices never match a channel and so have no effect.
      if (cfg_we && (32'(cfg_ch) == i)) begin
        mode_d[i]  = cfg_mode;
        val_d[i]   = cfg_val;
        phase_d[i] = '0;
        blink_d[i] = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
      tick_q    <= 1'b0;
      mode_q    <= '0;
      val_q     <= '0;
      phase_q   <= '0;
      blink_q   <= '1;
      led_q     <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      tick_q    <= tick_now;
      mode_q    <= mode_d;
      val_q     <= val_d;
      phase_q   <= phase_d;
      blink_q   <= blink_d;
      led_q     <= led_d;
    end
  end

  assign tick_o = tick_q;
  assign led_o  = led_q;

endmodule
